// File: rtl/host_comm_pkg.sv
// Shared constants, state encodings and frame helper for host_comm_master.
package host_comm_pkg;

  localparam int unsigned BAUD_DIV_DEFAULT = 108;
  localparam int unsigned FRAME_BITS       = 10;
  localparam int unsigned BIT_IDX_W        = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_HIGH,
    TX_LOW
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // Line level for bit position idx of an 8N1 frame: 0 start, 1..8 data LSB first, 9 stop.
  function automatic logic frame_bit(input logic [7:0] data, input logic [BIT_IDX_W-1:0] idx);
    logic [2:0] sel;
    logic       val;
    sel = 3'(idx - BIT_IDX_W'(1));
    if (idx == '0) begin
      val = 1'b0;
    end else if (idx >= BIT_IDX_W'(FRAME_BITS - 1)) begin
      val = 1'b1;
    end else begin
      val = data[sel];
    end
    return val;
  endfunction

endpackage

// File: rtl/host_uart_rx.sv
// 8N1 UART receiver with synchronizer and rdy/clr_rdy handshake.
// FRAME_ERR_EN: when defined, a zero stop bit raises frm_err_o instead of rdy_o.
module host_uart_rx
  import host_comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  input  logic       clr_rdy_i,
  output logic       rdy_o,
  output logic [7:0] data_o
`ifdef FRAME_ERR_EN
  ,
  output logic       frm_err_o
`endif
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);

  rx_state_e        state_q;
  logic             sync1_q;
  logic             sync2_q;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bitn_q;
  logic [7:0]       shreg_q;
  logic [7:0]       data_q;
  logic             rdy_q;
`ifdef FRAME_ERR_EN
  logic             frm_q;
`endif

  logic fall;
  logic full_bit;
  logic half_bit;

  assign fall     = prev_q & ~sync2_q;
  assign full_bit = (cnt_q == CNT_W'(BAUD_DIV - 1));
  assign half_bit = (cnt_q == CNT_W'(BAUD_DIV / 2 - 1));

  // Synchronizer, receive FSM and ready handshake; a completing byte overrides clr_rdy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RX_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bitn_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
`ifdef FRAME_ERR_EN
      frm_q   <= 1'b0;
`endif
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (clr_rdy_i) begin
        rdy_q <= 1'b0;
`ifdef FRAME_ERR_EN
        frm_q <= 1'b0;
`endif
      end
      case (state_q)
        RX_IDLE: begin
          if (fall) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (half_bit) begin
            cnt_q  <= '0;
            bitn_q <= '0;
            if (!sync2_q) begin
              state_q <= RX_DATA;
              rdy_q   <= 1'b0;
            end else begin
              state_q <= RX_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (full_bit) begin
            cnt_q   <= '0;
            shreg_q <= {sync2_q, shreg_q[7:1]};
            if (bitn_q == 3'd7) begin
              state_q <= RX_STOP;
            end else begin
              bitn_q <= bitn_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (full_bit) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            data_q  <= shreg_q;
`ifdef FRAME_ERR_EN
            if (sync2_q) begin
              rdy_q <= 1'b1;
              frm_q <= 1'b0;
            end else begin
              frm_q <= 1'b1;
            end
`else
            rdy_q <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign rdy_o  = rdy_q;
  assign data_o = data_q;
`ifdef FRAME_ERR_EN
  assign frm_err_o = frm_q;
`endif

endmodule

// File: rtl/host_comm_master.sv
// Host-side UART command master: sends 16-bit commands as two 8N1 bytes, receives response bytes.
// FRAME_ERR_EN: when defined, exposes frm_err for stop-bit errors on received bytes.
module host_comm_master
  import host_comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_cmplt,
  output logic        rdy,
  output logic [7:0]  rx_data,
  input  logic        clr_rdy
`ifdef FRAME_ERR_EN
  ,
  output logic        frm_err
`endif
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);

  tx_state_e            state_q;
  logic [15:0]          shadow_q;
  logic [CNT_W-1:0]     baud_q;
  logic [BIT_IDX_W-1:0] bit_q;
  logic                 tx_q;
  logic                 cmplt_q;
  logic                 fin_q;

  logic [7:0] cur_byte;

  assign cur_byte = (state_q == TX_HIGH) ? shadow_q[15:8] : shadow_q[7:0];

  // Command sequencer and bit shifter; the low byte starts right after the high stop bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= TX_IDLE;
      shadow_q <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      cmplt_q  <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      fin_q <= 1'b0;
      if (fin_q) begin
        cmplt_q <= 1'b1;
      end
      case (state_q)
        TX_IDLE: begin
          if (snd_cmd) begin
            shadow_q <= cmd;
            state_q  <= TX_HIGH;
            baud_q   <= '0;
            bit_q    <= '0;
            tx_q     <= 1'b0;
            cmplt_q  <= 1'b0;
          end
        end
        TX_HIGH, TX_LOW: begin
          if (baud_q == CNT_W'(BAUD_DIV - 1)) begin
            baud_q <= '0;
            if (bit_q == BIT_IDX_W'(FRAME_BITS - 1)) begin
              bit_q <= '0;
              if (state_q == TX_HIGH) begin
                state_q <= TX_LOW;
                tx_q    <= 1'b0;
              end else begin
                state_q <= TX_IDLE;
                tx_q    <= 1'b1;
                fin_q   <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + BIT_IDX_W'(1);
              tx_q  <= frame_bit(cur_byte, bit_q + BIT_IDX_W'(1));
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign TX        = tx_q;
  assign cmd_cmplt = cmplt_q;

  host_uart_rx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (RX),
    .clr_rdy_i (clr_rdy),
    .rdy_o     (rdy),
    .data_o    (rx_data)
`ifdef FRAME_ERR_EN
    ,
    .frm_err_o (frm_err)
`endif
  );

endmodule

// File: tb/tb_host_comm_master.sv
// Directed self-checking bench for host_comm_master (FRAME_ERR_EN selects frame-error checks).
module tb_host_comm_master;

  localparam int BD = 108;

  logic        clk;
  logic        rst;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_cmplt;
  logic        rdy;
  logic [7:0]  rx_data;
  logic        clr_rdy;
`ifdef FRAME_ERR_EN
  logic        frm_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  host_comm_master #(.BAUD_DIV(BD)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .TX        (TX),
    .cmd       (cmd),
    .snd_cmd   (snd_cmd),
    .cmd_cmplt (cmd_cmplt),
    .rdy       (rdy),
    .rx_data   (rx_data),
    .clr_rdy   (clr_rdy)
`ifdef FRAME_ERR_EN
    ,
    .frm_err   (frm_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic rx_bit(input logic v);
    RX = v;
    repeat (BD) @(negedge clk);
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic stop);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(b[i]);
    rx_bit(stop);
    RX = 1'b1;
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    @(negedge clk);
  endtask

  // Sends c and samples TX mid-bit for all 20 bits; optionally re-pulses snd_cmd after bit inj.
  task automatic tx_cmd(input logic [15:0] c, input int inj, output logic [19:0] bits);
    @(negedge clk);
    cmd = c;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    check("cmplt_clr_on_send", cmd_cmplt, 1'b0);
    repeat (BD / 2) @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      bits[k] = TX;
      if (k < 19) begin
        if (k == inj) begin
          cmd = 16'hFFFF;
          snd_cmd = 1'b1;
          @(negedge clk);
          snd_cmd = 1'b0;
          repeat (BD - 1) @(negedge clk);
        end else begin
          repeat (BD) @(negedge clk);
        end
      end
    end
    repeat (BD / 2) @(negedge clk);
    check("cmplt_before_2160", cmd_cmplt, 1'b0);
    @(negedge clk);
    check("cmplt_at_2161", cmd_cmplt, 1'b1);
  endtask

  initial begin
    logic [19:0] bits;
    logic        tx_all_high;
    rst = 1'b1;
    RX = 1'b1;
    cmd = '0;
    snd_cmd = 1'b0;
    clr_rdy = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_tx", TX, 1'b1);
    check("rst_cmplt", cmd_cmplt, 1'b0);
    check("rst_rdy", rdy, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
`ifdef FRAME_ERR_EN
    check("rst_frm_err", frm_err, 1'b0);
`endif
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Command 0x0612
    tx_cmd(16'h0612, -1, bits);
    check("tx0612_hi_frame", bits[9:0], 10'b1_00000110_0);
    check("tx0612_lo_frame", bits[19:10], 10'b1_00010010_0);

    // Single response byte and clear
    rx_byte(8'hA5, 1'b1);
    check("rxA5_rdy", rdy, 1'b1);
    check("rxA5_data", rx_data, 8'hA5);
    pulse_clr();
    check("rxA5_clr_rdy", rdy, 1'b0);
    check("rxA5_data_kept", rx_data, 8'hA5);

    // Back-to-back bytes without clr_rdy
    rx_byte(8'h12, 1'b1);
    check("rx12_rdy", rdy, 1'b1);
    check("rx12_data", rx_data, 8'h12);
    rx_bit(1'b0);
    check("rx34_start_clears_rdy", rdy, 1'b0);
    for (int i = 0; i < 8; i++) rx_bit(8'h34 >> i);
    rx_bit(1'b1);
    check("rx34_rdy", rdy, 1'b1);
    check("rx34_data", rx_data, 8'h34);
    pulse_clr();

    // Second snd_cmd mid-transmission is ignored
    tx_cmd(16'hC300, 5, bits);
    check("txC3_hi_frame", bits[9:0], 10'b1_11000011_0);
    check("tx00_lo_frame", bits[19:10], 10'b1_00000000_0);
    tx_all_high = 1'b1;
    repeat (12 * BD) begin
      @(negedge clk);
      if (TX !== 1'b1) tx_all_high = 1'b0;
    end
    check("no_third_byte", tx_all_high, 1'b1);
    check("cmplt_holds", cmd_cmplt, 1'b1);

    // Reset mid-byte, then a fresh command
    cmd = 16'h0F0F;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_tx", TX, 1'b1);
    check("midrst_cmplt", cmd_cmplt, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tx_cmd(16'h5A81, -1, bits);
    check("tx5A_hi_frame", bits[9:0], 10'b1_01011010_0);
    check("tx81_lo_frame", bits[19:10], 10'b1_10000001_0);

    // 20-clock low glitch on RX
    rx_byte(8'h34, 1'b1);
    pulse_clr();
    RX = 1'b0;
    repeat (20) @(negedge clk);
    RX = 1'b1;
    repeat (12 * BD) @(negedge clk);
    check("glitch_rdy", rdy, 1'b0);
    check("glitch_data", rx_data, 8'h34);

    // Stop bit sampled as 0
    rx_byte(8'h3C, 1'b0);
    repeat (4) @(negedge clk);
    check("badstop_data", rx_data, 8'h3C);
`ifdef FRAME_ERR_EN
    check("badstop_frm_err", frm_err, 1'b1);
    check("badstop_rdy", rdy, 1'b0);
    pulse_clr();
    check("badstop_frm_clr", frm_err, 1'b0);
`else
    check("badstop_rdy", rdy, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/host_comm_master.md
Name: host_comm_master

Overview:
- Host-side UART command master used in the logic-analyzer system bench.
- Each request sends one 16-bit command to the LA core as two 8N1 UART bytes, high byte first.
- Independently receives single-byte responses from the core (e.g. 0xA5 ack, dump bytes) and presents them through a ready/clear handshake.
- Sits between the bench stimulus and the DUT RX/TX pins; runs on the 100 MHz system clock.

Parameters:
- BAUD_DIV, 108, clocks per UART bit period (100 MHz / 921600 baud).

Ports:
- clk  input  1  system clock, 100 MHz; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- RX  input  1  serial in from the core's TX; idle high.
- TX  output  1  serial out to the core's RX; idle high.
- cmd  input  16  command word; cmd[15:8] is sent first, then cmd[7:0].
- snd_cmd  input  1  one-clock pulse that starts a command send.
- cmd_cmplt  output  1  high once both bytes are fully sent.
- rdy  output  1  a response byte is available.
- rx_data  output  8  last received byte.
- clr_rdy  input  1  one-clock pulse that clears rdy.

Behaviour:
- Reset values:
  - TX=1, cmd_cmplt=0, rdy=0, rx_data=8'h00.
  - Both FSMs go to IDLE; all counters are 0.
- Transmit FSM states: IDLE -> HIGH (send cmd[15:8]) -> LOW (send cmd[7:0]) -> IDLE.
  - cmd is latched into a 16-bit shadow register on the snd_cmd clock.
  - On that same clock, cmd_cmplt clears to 0.
- Byte frame:
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit is held exactly BAUD_DIV clocks, so one byte takes 10*BAUD_DIV clocks.
- The low byte's start bit follows the high byte's stop bit immediately, with no idle gap.
- cmd_cmplt:
  - Rises on the clock after the low byte's stop-bit period ends.
  - Stays high until the next accepted snd_cmd.
  - Latency from snd_cmd to cmd_cmplt is 20*BAUD_DIV+1 clocks.
- snd_cmd while the transmit FSM is not IDLE is ignored; the shadow register is unchanged.
- Receiver:
  - RX passes through a 2-flop synchronizer with both flops reset to 1.
  - IDLE: a falling edge of the synchronized RX starts a byte.
  - The receiver waits BAUD_DIV/2 clocks and re-checks the start bit; if RX is high again the start is a glitch and the FSM returns to IDLE.
  - It then samples 8 data bits at BAUD_DIV intervals into a shift register, LSB first, then samples the stop bit.
- Completing a byte:
  - At stop-bit sample time, rx_data is loaded and rdy is set.
  - A stop bit of 0 is still accepted unless FRAME_ERR_EN is defined.
- Clearing rdy:
  - rdy is cleared by clr_rdy, or by detection of the next valid start bit.
  - If clr_rdy arrives on the same clock as a byte completes, the set wins and rdy=1.
- The receive and transmit paths are fully independent, so full duplex is supported.
- An asserted rst at any time aborts both paths immediately: TX returns high and partial bytes are discarded.

Optional Feature:
- Macro: FRAME_ERR_EN.
- Defined:
  - Adds output port frm_err (1 bit, reset 0).
  - frm_err is set when a stop bit samples 0; in that case rx_data is still loaded, but rdy is NOT set.
  - frm_err is cleared by clr_rdy or by the next valid byte.
- Undefined:
  - No frm_err port; every byte sets rdy regardless of the stop bit.

Decomposition:
- Package host_comm_pkg holds:
  - BAUD_DIV default;
  - typedef enum for tx states {IDLE, HIGH, LOW};
  - typedef enum for rx states {IDLE, START, DATA, STOP};
  - bit-count constant of 10 bits per frame.
- Sub-module host_uart_rx is the receiver (synchronizer, FSM, rdy/clr_rdy handshake).
- The transmit byte shifter and the command sequencer stay in the top level.

Test Plan:
- Reset: hold rst for 5 clocks -> TX=1, cmd_cmplt=0, rdy=0, rx_data=00.
- Send cmd=16'h0612 with a snd_cmd pulse:
  - TX shows frame 0,0110_0000,1 then 0,0100_1000,1 (LSB first), each bit 108 clocks.
  - cmd_cmplt rises 2161 clocks after snd_cmd.
- Drive an 0xA5 8N1 frame on RX at BAUD_DIV=108 -> rdy=1 and rx_data=A5 at the stop-bit sample; a clr_rdy pulse then gives rdy=0 and rx_data stays A5.
- Back-to-back RX bytes 0x12, 0x34 without clr_rdy -> rdy drops at the second start bit, then rdy=1 with rx_data=34.
- snd_cmd with 16'hC300 pulsed again mid-transmission -> second pulse ignored; exactly two bytes C3, 00 are sent.
- Edge cases:
  - rst asserted mid-byte -> TX=1 on the next edge, then a fresh snd_cmd completes normally.
  - A 20-clock low glitch on RX -> rdy stays 0.
  - With FRAME_ERR_EN, a stop bit of 0 -> frm_err=1, rdy=0.
